// File: rtl/z80_busctl.sv
// z80_busctl: Z80 sound-CPU bus controller.
// Decodes each Z80 memory cycle into one of four actions: an 8 KB sound-RAM
// access (mirrored over 0000-3FFF), a write to the 9-bit bank register at
// 6000-60FF, a banked access through the 8000-FFFF window onto the main bus
// (stalling the Z80 with WAIT until the main bus acknowledges), or an
// unmapped access that reads back FF.
//
// Handshake on the banked port: bank_req rises the cycle after the access is
// decoded and stays high, with bank_addr/bank_we/bank_do held stable, until
// bank_ack is sampled high on a rising mclk edge; that edge completes the
// transfer (read data captured from bank_di) and drops bank_req. bank_ack is
// only meaningful while the controller is in the BREQ state.
//
// Every action happens exactly once per Z80 cycle: after an action the
// controller parks in DONE until the strobes are released.

module z80_busctl (
  input  logic        mclk,
  input  logic        reset,      // synchronous, active-low
  input  logic [15:0] address,
  input  logic [7:0]  data_o,     // Z80 write data
  output logic [7:0]  data_i,     // read data back to the Z80
  input  logic        mreq,       // active-low
  input  logic        rd,         // active-low
  input  logic        wr,         // active-low
  input  logic        rfsh,       // active-low
  output logic        wait_n,     // Z80 WAIT, active-low
  output logic [12:0] ram_a,
  output logic [7:0]  ram_do,
  input  logic [7:0]  ram_di,
  output logic        ram_ce,
  output logic        ram_we,
  output logic        bank_req,
  input  logic        bank_ack,
  output logic [23:0] bank_addr,
  output logic        bank_we,
  output logic [7:0]  bank_do,
  input  logic [7:0]  bank_di,
  output logic [8:0]  bank,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAM  = 2'd1,
    ST_BREQ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM      = 2'd0,
    RG_BANKREG  = 2'd1,
    RG_WINDOW   = 2'd2,
    RG_UNMAPPED = 2'd3
  } region_t;

  state_t  state;
  state_t  state_nx;
  region_t region;
  logic    access_start;
  logic    cycle_end;
  logic    lat_wr;        // direction of the access in flight (1 = write)

  assign state_dbg = state;

  // Strobe qualification and address decode of the live bus.
  always_comb begin
    access_start = 1'b0;
    cycle_end    = 1'b0;
    region       = RG_UNMAPPED;
    // Refresh cycles also drive MREQ low; they must never start an access.
    access_start = !mreq && rfsh && (!rd || !wr);
    cycle_end    = mreq || (rd && wr);
    if (address[15:14] == 2'b00) begin
      region = RG_RAM;            // A13 ignored: 2000-3FFF mirrors 0000-1FFF
    end else if (address[15]) begin
      region = RG_WINDOW;
    end else if (address[15:8] == 8'h60) begin
      region = RG_BANKREG;
    end else begin
      region = RG_UNMAPPED;
    end
  end

  // Next-state logic: one transition per mclk.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (access_start) begin
          case (region)
            RG_RAM:    state_nx = ST_RAM;
            RG_WINDOW: state_nx = ST_BREQ;
            default:   state_nx = ST_DONE;
          endcase
        end
      end
      ST_RAM:  state_nx = ST_DONE;
      ST_BREQ: begin
        if (bank_ack) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cycle_end) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered datapath: latches the access at the start edge and completes
  // it in RAM/BREQ. ram_ce/ram_we default low so they only ever pulse for the
  // single cycle spent in RAM.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      data_i    <= 8'hFF;
      wait_n    <= 1'b1;
      ram_a     <= 13'h0000;
      ram_do    <= 8'h00;
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      bank_req  <= 1'b0;
      bank_addr <= 24'h000000;
      bank_we   <= 1'b0;
      bank_do   <= 8'h00;
      bank      <= 9'h000;
      lat_wr    <= 1'b0;
    end else begin
      ram_ce <= 1'b0;
      ram_we <= 1'b0;

      if (state == ST_IDLE && access_start) begin
        lat_wr <= !wr;
        case (region)
          RG_RAM: begin
            ram_ce <= 1'b1;
            ram_we <= !wr;
            ram_a  <= address[12:0];
            ram_do <= data_o;
          end
          RG_BANKREG: begin
            // Serial bank load: each write shifts D0 in at the top.
            if (!wr) begin
              bank <= {data_o[0], bank[8:1]};
            end else begin
              data_i <= 8'hFF;
            end
          end
          RG_WINDOW: begin
            bank_req  <= 1'b1;
            wait_n    <= 1'b0;
            bank_addr <= {bank, address[14:0]};
            bank_we   <= !wr;
            bank_do   <= data_o;
          end
          default: begin
            // Unmapped: writes vanish, reads float high.
            if (wr) begin
              data_i <= 8'hFF;
            end
          end
        endcase
      end

      if (state == ST_RAM && !lat_wr) begin
        data_i <= ram_di;
      end

      if (state == ST_BREQ && bank_ack) begin
        if (!lat_wr) begin
          data_i <= bank_di;
        end
        bank_req <= 1'b0;
        wait_n   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z80_busctl.sv
// tb_z80_busctl: directed bench for the Z80 bus controller.
// Read results are pushed to exp_q when the read is driven and popped when the
// access completes; strobe pulses are counted by edge monitors.

module tb_z80_busctl;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAM  = 2'd1;
  localparam logic [1:0] S_BREQ = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic        mclk;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_o;
  logic [7:0]  data_i;
  logic        mreq, rd, wr, rfsh;
  logic        wait_n;
  logic [12:0] ram_a;
  logic [7:0]  ram_do;
  logic [7:0]  ram_di;
  logic        ram_ce, ram_we;
  logic        bank_req, bank_ack;
  logic [23:0] bank_addr;
  logic        bank_we;
  logic [7:0]  bank_do;
  logic [7:0]  bank_di;
  logic [8:0]  bank;
  logic [1:0]  state_dbg;

  logic [7:0] exp_q[$];
  int checks;
  int errors;
  int ce_cnt, we_cnt, req_cnt;

  z80_busctl dut (
    .mclk(mclk), .reset(reset), .address(address), .data_o(data_o),
    .data_i(data_i), .mreq(mreq), .rd(rd), .wr(wr), .rfsh(rfsh),
    .wait_n(wait_n), .ram_a(ram_a), .ram_do(ram_do), .ram_di(ram_di),
    .ram_ce(ram_ce), .ram_we(ram_we), .bank_req(bank_req),
    .bank_ack(bank_ack), .bank_addr(bank_addr), .bank_we(bank_we),
    .bank_do(bank_do), .bank_di(bank_di), .bank(bank),
    .state_dbg(state_dbg)
  );

  // Clock.
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Pulse monitors: count cycles in which each strobe was high.
  always @(posedge mclk) begin
    if (ram_ce)   ce_cnt  <= ce_cnt + 1;
    if (ram_we)   we_cnt  <= we_cnt + 1;
    if (bank_req) req_cnt <= req_cnt + 1;
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [7:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, data_i);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {24'h0, data_i}, {24'h0, exp});
    end
  endtask

  task automatic idle_bus();
    mreq = 1'b1; rd = 1'b1; wr = 1'b1; rfsh = 1'b1;
  endtask

  task automatic start_read(input logic [15:0] a);
    address = a; mreq = 1'b0; rd = 1'b0; wr = 1'b1; rfsh = 1'b1;
  endtask

  task automatic start_write(input logic [15:0] a, input logic [7:0] d);
    address = a; data_o = d; mreq = 1'b0; rd = 1'b1; wr = 1'b0; rfsh = 1'b1;
  endtask

  initial begin
    int c0;
    logic [23:0] addr_hold;
    checks = 0; errors = 0;
    ce_cnt = 0; we_cnt = 0; req_cnt = 0;
    reset = 1'b0;
    address = 16'h0000; data_o = 8'h00;
    ram_di = 8'h00; bank_di = 8'h00; bank_ack = 1'b0;
    idle_bus();

    // Reset state.
    tick(); tick();
    check("rst_state", state_dbg, S_IDLE);
    check("rst_data_i", data_i, 8'hFF);
    check("rst_wait", wait_n, 1'b1);
    check("rst_ram_ce", ram_ce, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_bank_req", bank_req, 1'b0);
    check("rst_bank_we", bank_we, 1'b0);
    check("rst_bank", bank, 9'h000);
    check("rst_bank_addr", bank_addr, 24'h000000);
    check("rst_ram_a", ram_a, 13'h0000);
    check("rst_ram_do", ram_do, 8'h00);
    check("rst_bank_do", bank_do, 8'h00);
    reset = 1'b1;
    tick();

    // Mirrored RAM read at 2123.
    ram_di = 8'h5A;
    c0 = ce_cnt;
    start_read(16'h2123);
    exp_q.push_back(8'h5A);
    tick();
    check("ramrd_state", state_dbg, S_RAM);
    check("ramrd_ce", ram_ce, 1'b1);
    check("ramrd_we", ram_we, 1'b0);
    check("ramrd_addr", ram_a, 13'h0123);
    check("ramrd_wait", wait_n, 1'b1);
    tick();
    check_pop("ramrd_data");
    check("ramrd_ce_off", ram_ce, 1'b0);
    check("ramrd_wait2", wait_n, 1'b1);
    check("ramrd_done", state_dbg, S_DONE);
    idle_bus();
    tick();
    check("ramrd_idle", state_dbg, S_IDLE);
    check("ramrd_ce_cnt", ce_cnt - c0, 1);

    // Bank register read returns FF.
    start_read(16'h6042);
    exp_q.push_back(8'hFF);
    tick();
    check("bankreg_rd_state", state_dbg, S_DONE);
    check_pop("bankreg_rd_data");
    idle_bus();
    tick();

    // RAM write held for 10 cycles: exactly one write pulse.
    c0 = we_cnt;
    start_write(16'h0010, 8'h3C);
    tick();
    check("ramwr_we", ram_we, 1'b1);
    check("ramwr_addr", ram_a, 13'h0010);
    check("ramwr_do", ram_do, 8'h3C);
    for (int i = 0; i < 9; i++) tick();
    check("ramwr_hold_state", state_dbg, S_DONE);
    idle_bus();
    tick();
    check("ramwr_we_cnt", we_cnt - c0, 1);
    check("ramwr_idle", state_dbg, S_IDLE);

    // Refresh cycle never starts an access.
    c0 = ce_cnt;
    address = 16'h0010; mreq = 1'b0; rfsh = 1'b0; rd = 1'b0; wr = 1'b1;
    tick(); tick(); tick();
    check("rfsh_ce_cnt", ce_cnt - c0, 0);
    check("rfsh_state", state_dbg, S_IDLE);
    idle_bus();
    tick();

    // Nine serial writes into the bank register.
    for (int i = 0; i < 9; i++) begin
      start_write(16'h6000 + 16'(i * 3), (i % 2 == 0) ? 8'hA5 : 8'h5A);
      tick();
      if (i == 0) check("bank_first", bank, 9'h100);
      tick(); tick();
      idle_bus();
      tick();
    end
    check("bank_final", bank, 9'h155);

    // Banked read at 8004, ack after 7 cycles of request.
    bank_di = 8'hC3;
    c0 = req_cnt;
    start_read(16'h8004);
    exp_q.push_back(8'hC3);
    tick();
    check("breq_state", state_dbg, S_BREQ);
    check("breq_req", bank_req, 1'b1);
    check("breq_wait", wait_n, 1'b0);
    check("breq_addr", bank_addr, 24'hAA8004);
    check("breq_we", bank_we, 1'b0);
    addr_hold = bank_addr;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("breq_hold_req", bank_req, 1'b1);
      check("breq_hold_wait", wait_n, 1'b0);
      check("breq_hold_addr", bank_addr, 24'hAA8004);
    end
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    check("back_req_off", bank_req, 1'b0);
    check("back_wait", wait_n, 1'b1);
    check("back_state", state_dbg, S_DONE);
    check_pop("back_data");
    check("breq_req_cnt", req_cnt - c0, 7);
    idle_bus();
    tick();

    // Banked write carries direction and data.
    start_write(16'hFFFE, 8'h81);
    tick();
    check("bwr_we", bank_we, 1'b1);
    check("bwr_do", bank_do, 8'h81);
    check("bwr_addr", bank_addr, 24'hAAFFFE);
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    check("bwr_data_keep", data_i, 8'hC3);
    idle_bus();
    tick();

    // Unmapped read and write.
    c0 = ce_cnt;
    start_read(16'h4000);
    exp_q.push_back(8'hFF);
    tick();
    check("unm_state", state_dbg, S_DONE);
    check("unm_req", bank_req, 1'b0);
    check_pop("unm_data");
    idle_bus();
    tick();
    start_write(16'h7000, 8'h00);
    tick();
    idle_bus();
    tick();
    check("unm_ce_cnt", ce_cnt - c0, 0);
    check("unm_bank", bank, 9'h155);

    // Stray ack in IDLE.
    bank_ack = 1'b1;
    tick(); tick();
    bank_ack = 1'b0;
    check("stray_state", state_dbg, S_IDLE);
    check("stray_req", bank_req, 1'b0);
    check("stray_data", data_i, 8'hFF);

    // Reset two cycles into BREQ, then a late ack.
    ram_di = 8'h00;
    bank_di = 8'h77;
    start_read(16'h8123);
    tick();
    check("rstb_in_breq", state_dbg, S_BREQ);
    tick();
    reset = 1'b0;
    tick();
    check("rstb_req", bank_req, 1'b0);
    check("rstb_wait", wait_n, 1'b1);
    check("rstb_bank", bank, 9'h000);
    check("rstb_addr", bank_addr, 24'h000000);
    check("rstb_state", state_dbg, S_IDLE);
    idle_bus();
    tick();
    reset = 1'b1;
    bank_ack = 1'b1;
    tick();
    bank_ack = 1'b0;
    tick();
    check("rstb_ack_data", data_i, 8'hFF);
    check("rstb_ack_state", state_dbg, S_IDLE);

    // Strobe already active when reset releases starts a new access.
    ram_di = 8'h96;
    reset = 1'b0;
    start_read(16'h0456);
    tick();
    check("rel_hold_state", state_dbg, S_IDLE);
    reset = 1'b1;
    exp_q.push_back(8'h96);
    tick();
    check("rel_state", state_dbg, S_RAM);
    check("rel_ram_a", ram_a, 13'h0456);
    tick();
    check_pop("rel_data");
    idle_bus();
    tick();

    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
